rr_req_ack_arbiter: RTL and testbench
=====================================

Name: rr_req_ack_arbiter

Overview:
- Round-robin arbiter sharing one fixed-latency resource among N_REQ requesters over a level req / pulsed ack handshake.
- Grants one requester at a time and returns ack exactly ACK_DLY cycles after the grant edge. This is the `req |-> ##ACK_DLY ack` contract the team's SVA benches check.
- Sits between client blocks and the shared resource; drives gnt/gnt_id to the resource mux.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- ACK_DLY, 4, cycles from grant edge to ack pulse (>=1).
- ID_W, $clog2(N_REQ), width of gnt_id.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per requester; held until its ack is seen.
- gnt  out  N_REQ  one-hot grant; high from grant edge through the ack cycle.
- ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- gnt_id  out  ID_W  index of current/last granted requester.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst sampled high at posedge):
  - state=IDLE; gnt=0, ack=0, busy=0, gnt_id=0.
  - rr pointer=N_REQ-1, so req[0] has first priority.
  - Counter cleared.
  - Reset mid-transaction aborts it; no ack is issued.
- All outputs are registered.
- States: IDLE, WAIT, ACK, RELEASE.
- IDLE:
  - If req!=0 at edge k, choose the first set bit searching from (ptr+1) mod N_REQ upward with wrap.
  - Set gnt[i]=1, gnt_id=i, ptr=i, busy=1.
  - Load counter with ACK_DLY-1.
  - If ACK_DLY==1, go directly to ACK; else go to WAIT.
  - If req==0, remain in IDLE; outputs stay 0. gnt_id holds its last value.
- WAIT:
  - Counter decrements each edge.
  - When counter==1 at an edge, go to ACK.
  - Net timing: ack[i] is high in exactly the cycle starting at edge k+ACK_DLY.
- ACK:
  - ack[i]=1 and gnt[i]=1 for exactly one cycle.
  - At the next edge: gnt=0, ack=0. Go to IDLE if req[i]==0, else RELEASE.
- RELEASE:
  - gnt=0, busy=1. Wait until req[i] is sampled low, then go to IDLE.
  - Prevents one held request from being served twice.
- Withdrawn request: if req[i] drops during WAIT, the transaction still completes and ack[i] is still pulsed (resource already started).
- Other requests arriving while busy are ignored until IDLE; they are not latched. Requesters hold req.
- Simultaneous requests: exactly one grant, chosen by rotating priority.
- Grants are never issued while busy.
- Minimum grant-to-grant spacing: ACK_DLY+2 cycles.
- Pointer wraps N_REQ-1 -> 0.
- Invariants:
  - gnt is one-hot or zero.
  - ack is a subset of gnt.
  - ack is never high two consecutive cycles.

Test Plan:
- Single request, defaults: req[2]=1 at edge 1 -> gnt=4'b0100 and gnt_id=2 after edge 1; ack=4'b0100 only in the cycle after edge 5. Drop req after ack -> busy=0 after edge 6.
- Simultaneous requests: req=4'b1111 held, each dropped after its ack -> grants issued in order 0,1,2,3,0. Every ack lands exactly 4 cycles after its grant edge.
- Held request: req[1] kept high 3 cycles past its ack -> state RELEASE, no second gnt[1]. After req[1] falls, the next grant goes to another pending requester before 1.
- Withdraw: req[3] granted, then dropped 2 cycles later -> ack[3] still pulses at grant+4; no RELEASE phase.
- Reset mid-op: rst=1 at grant+2 -> gnt=0, ack=0, busy=0 after that edge; no ack ever appears. Next req[0] and req[3] together -> req[0] granted first.
- ACK_DLY=1 build: req[0] at edge k -> ack[0] in the cycle after edge k+1.
- All scenarios run with an SVA property `gnt edge |-> ##ACK_DLY ack` asserting on every grant.

Source files
------------

// File: rtl/rr_req_ack_arbiter_if.sv
// Request/grant/ack bundle between the client blocks and the round-robin arbiter.
// The client side drives req; the arbiter drives the grant, ack, id and busy signals.
interface rr_req_ack_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] ack;
    logic [ID_W-1:0]  gnt_id;
    logic             busy;

    modport master (output req, input gnt, input ack, input gnt_id, input busy);
    modport slave  (input req, output gnt, output ack, output gnt_id, output busy);
endinterface

// File: rtl/rr_req_ack_arbiter.sv
// Round-robin arbiter for one fixed-latency resource.
// Grants one requester at a time and pulses its ack ACK_DLY cycles after the grant edge.
module rr_req_ack_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ACK_DLY = 4,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_req_ack_arbiter_if.slave  bus
);
    localparam int CNT_W = (ACK_DLY > 1) ? $clog2(ACK_DLY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, RELEASE} state_t;

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  pick;
    logic             found;
    int unsigned      idx;

    // First set request searching upward from ptr+1, wrapping at N_REQ.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(ptr) + i) % 32'(N_REQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus.gnt    <= '0;
            bus.ack    <= '0;
            bus.busy   <= 1'b0;
            bus.gnt_id <= '0;
            ptr        <= ID_W'(N_REQ - 1);
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.gnt       <= '0;
                        bus.gnt[pick] <= 1'b1;
                        bus.gnt_id    <= pick;
                        ptr           <= pick;
                        bus.busy      <= 1'b1;
                        cnt           <= CNT_W'(ACK_DLY - 1);
                        state         <= WAIT;
                    end
                end
                // Counter runs ACK_DLY-1 .. 0; ack is registered on the edge after it
                // reaches zero, so the pulse lands exactly ACK_DLY edges after the grant.
                WAIT: begin
                    if (cnt == '0) begin
                        bus.ack <= bus.gnt;
                        state   <= ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    bus.gnt <= '0;
                    bus.ack <= '0;
                    if (bus.req[ptr]) begin
                        state <= RELEASE;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!bus.req[ptr]) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_req_ack_arbiter.sv
// Directed bench for rr_req_ack_arbiter: default build (ACK_DLY=4) plus an ACK_DLY=1 build.
// Inputs change 1 time unit after each posedge; outputs are checked at that same point.
module tb_rr_req_ack_arbiter;
    localparam int N = 4;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    rr_req_ack_arbiter_if #(.N_REQ(N), .ID_W(W)) bus0 ();
    rr_req_ack_arbiter_if #(.N_REQ(N), .ID_W(W)) bus1 ();

    rr_req_ack_arbiter #(.N_REQ(N), .ACK_DLY(4), .ID_W(W)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    rr_req_ack_arbiter #(.N_REQ(N), .ACK_DLY(1), .ID_W(W)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    a_lat0: assert property (@(posedge clk) disable iff (rst)
        $rose(|bus0.gnt) |-> ##4 ((bus0.ack & bus0.gnt) != '0))
        else begin mismatched++; $display("FAIL sva_lat0: ack not seen 4 cycles after grant at %0t", $time); end
    a_lat1: assert property (@(posedge clk) disable iff (rst)
        $rose(|bus1.gnt) |-> ##1 ((bus1.ack & bus1.gnt) != '0))
        else begin mismatched++; $display("FAIL sva_lat1: ack not seen 1 cycle after grant at %0t", $time); end
    a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus0.gnt))
        else begin mismatched++; $display("FAIL sva_onehot: gnt=%b", bus0.gnt); end
    a_subset0: assert property (@(posedge clk) disable iff (rst) (bus0.ack & ~bus0.gnt) == '0)
        else begin mismatched++; $display("FAIL sva_subset: ack=%b gnt=%b", bus0.ack, bus0.gnt); end
    a_nocons0: assert property (@(posedge clk) disable iff (rst) !((|bus0.ack) && $past(|bus0.ack)))
        else begin mismatched++; $display("FAIL sva_ack_twice: ack=%b", bus0.ack); end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.req = '0;
        bus1.req = '0;
        tick();
        tick();
        rst = 1'b0;
        compared++;
        if (bus0.gnt !== 4'b0000 || bus0.ack !== 4'b0000 || bus0.busy !== 1'b0 || bus0.gnt_id !== 2'd0) begin
            mismatched++;
            $display("FAIL reset: gnt=%b ack=%b busy=%b id=%0d expected 0000 0000 0 0",
                     bus0.gnt, bus0.ack, bus0.busy, bus0.gnt_id);
        end
    endtask

    task automatic test_single();
        bus0.req = 4'b0100;
        tick();
        compared++;
        if (bus0.gnt !== 4'b0100 || bus0.gnt_id !== 2'd2 || bus0.busy !== 1'b1 || bus0.ack !== 4'b0000) begin
            mismatched++;
            $display("FAIL single_grant: gnt=%b id=%0d busy=%b ack=%b expected 0100 2 1 0000",
                     bus0.gnt, bus0.gnt_id, bus0.busy, bus0.ack);
        end
        for (int j = 1; j <= 4; j++) begin
            tick();
            compared++;
            if (bus0.ack !== ((j == 4) ? 4'b0100 : 4'b0000) || bus0.gnt !== 4'b0100) begin
                mismatched++;
                $display("FAIL single_ack_t%0d: ack=%b gnt=%b", j, bus0.ack, bus0.gnt);
            end
        end
        bus0.req = '0;
        tick();
        compared++;
        if (bus0.busy !== 1'b0 || bus0.gnt !== 4'b0000 || bus0.ack !== 4'b0000) begin
            mismatched++;
            $display("FAIL single_done: busy=%b gnt=%b ack=%b expected 0 0000 0000",
                     bus0.busy, bus0.gnt, bus0.ack);
        end
    endtask

    task automatic test_simultaneous();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus0.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            e = '0;
            e[order[n]] = 1'b1;
            tick();
            compared++;
            if (bus0.gnt !== e || bus0.gnt_id !== 2'(order[n])) begin
                mismatched++;
                $display("FAIL rr_grant%0d: gnt=%b id=%0d expected %b %0d",
                         n, bus0.gnt, bus0.gnt_id, e, order[n]);
            end
            for (int j = 1; j <= 4; j++) begin
                tick();
                compared++;
                if (bus0.ack !== ((j == 4) ? e : 4'b0000)) begin
                    mismatched++;
                    $display("FAIL rr_ack%0d_t%0d: ack=%b", n, j, bus0.ack);
                end
            end
            bus0.req[order[n]] = 1'b0;
            tick();
            compared++;
            if (bus0.busy !== 1'b0 || bus0.gnt !== 4'b0000) begin
                mismatched++;
                $display("FAIL rr_idle%0d: busy=%b gnt=%b expected 0 0000", n, bus0.busy, bus0.gnt);
            end
            if (n == 0) bus0.req[0] = 1'b1;
        end
    endtask

    task automatic test_held();
        bus0.req = 4'b0010;
        tick();
        compared++;
        if (bus0.gnt !== 4'b0010 || bus0.gnt_id !== 2'd1) begin
            mismatched++;
            $display("FAIL held_grant: gnt=%b id=%0d expected 0010 1", bus0.gnt, bus0.gnt_id);
        end
        for (int j = 1; j <= 4; j++) tick();
        compared++;
        if (bus0.ack !== 4'b0010) begin
            mismatched++;
            $display("FAIL held_ack: ack=%b expected 0010", bus0.ack);
        end
        bus0.req = 4'b0011;
        for (int j = 1; j <= 3; j++) begin
            tick();
            compared++;
            if (bus0.gnt !== 4'b0000 || bus0.busy !== 1'b1 || bus0.ack !== 4'b0000) begin
                mismatched++;
                $display("FAIL held_release_t%0d: gnt=%b busy=%b ack=%b expected 0000 1 0000",
                         j, bus0.gnt, bus0.busy, bus0.ack);
            end
        end
        bus0.req = 4'b0001;
        tick();
        compared++;
        if (bus0.busy !== 1'b0 || bus0.gnt !== 4'b0000) begin
            mismatched++;
            $display("FAIL held_exit: busy=%b gnt=%b expected 0 0000", bus0.busy, bus0.gnt);
        end
        bus0.req = 4'b0011;
        tick();
        compared++;
        if (bus0.gnt !== 4'b0001 || bus0.gnt_id !== 2'd0) begin
            mismatched++;
            $display("FAIL held_next: gnt=%b id=%0d expected 0001 0", bus0.gnt, bus0.gnt_id);
        end
        for (int j = 1; j <= 4; j++) tick();
        compared++;
        if (bus0.ack !== 4'b0001) begin
            mismatched++;
            $display("FAIL held_next_ack: ack=%b expected 0001", bus0.ack);
        end
        bus0.req = '0;
        tick();
    endtask

    task automatic test_withdraw();
        bus0.req = 4'b1000;
        tick();
        compared++;
        if (bus0.gnt !== 4'b1000 || bus0.gnt_id !== 2'd3) begin
            mismatched++;
            $display("FAIL wd_grant: gnt=%b id=%0d expected 1000 3", bus0.gnt, bus0.gnt_id);
        end
        tick();
        tick();
        bus0.req = '0;
        tick();
        compared++;
        if (bus0.ack !== 4'b0000 || bus0.gnt !== 4'b1000) begin
            mismatched++;
            $display("FAIL wd_hold: ack=%b gnt=%b expected 0000 1000", bus0.ack, bus0.gnt);
        end
        tick();
        compared++;
        if (bus0.ack !== 4'b1000) begin
            mismatched++;
            $display("FAIL wd_ack: ack=%b expected 1000", bus0.ack);
        end
        tick();
        compared++;
        if (bus0.busy !== 1'b0 || bus0.gnt !== 4'b0000) begin
            mismatched++;
            $display("FAIL wd_no_release: busy=%b gnt=%b expected 0 0000", bus0.busy, bus0.gnt);
        end
    endtask

    task automatic test_reset_midop();
        bus0.req = 4'b0010;
        tick();
        compared++;
        if (bus0.gnt !== 4'b0010) begin
            mismatched++;
            $display("FAIL rm_grant: gnt=%b expected 0010", bus0.gnt);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus0.req = '0;
        compared++;
        if (bus0.gnt !== 4'b0000 || bus0.ack !== 4'b0000 || bus0.busy !== 1'b0 || bus0.gnt_id !== 2'd0) begin
            mismatched++;
            $display("FAIL rm_reset: gnt=%b ack=%b busy=%b id=%0d expected 0000 0000 0 0",
                     bus0.gnt, bus0.ack, bus0.busy, bus0.gnt_id);
        end
        for (int j = 1; j <= 6; j++) begin
            tick();
            compared++;
            if (bus0.ack !== 4'b0000 || bus0.gnt !== 4'b0000) begin
                mismatched++;
                $display("FAIL rm_quiet_t%0d: ack=%b gnt=%b expected 0000 0000", j, bus0.ack, bus0.gnt);
            end
        end
        bus0.req = 4'b1001;
        tick();
        compared++;
        if (bus0.gnt !== 4'b0001 || bus0.gnt_id !== 2'd0) begin
            mismatched++;
            $display("FAIL rm_priority: gnt=%b id=%0d expected 0001 0", bus0.gnt, bus0.gnt_id);
        end
        for (int j = 1; j <= 4; j++) tick();
        compared++;
        if (bus0.ack !== 4'b0001) begin
            mismatched++;
            $display("FAIL rm_ack: ack=%b expected 0001", bus0.ack);
        end
        bus0.req = '0;
        tick();
    endtask

    task automatic test_ack_dly1();
        bus1.req = 4'b0001;
        tick();
        compared++;
        if (bus1.gnt !== 4'b0001 || bus1.ack !== 4'b0000 || bus1.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL d1_grant: gnt=%b ack=%b busy=%b expected 0001 0000 1",
                     bus1.gnt, bus1.ack, bus1.busy);
        end
        tick();
        compared++;
        if (bus1.ack !== 4'b0001 || bus1.gnt !== 4'b0001) begin
            mismatched++;
            $display("FAIL d1_ack: ack=%b gnt=%b expected 0001 0001", bus1.ack, bus1.gnt);
        end
        bus1.req = '0;
        tick();
        compared++;
        if (bus1.busy !== 1'b0 || bus1.ack !== 4'b0000 || bus1.gnt !== 4'b0000) begin
            mismatched++;
            $display("FAIL d1_done: busy=%b ack=%b gnt=%b expected 0 0000 0000",
                     bus1.busy, bus1.ack, bus1.gnt);
        end
    endtask

    initial begin
        bus0.req = '0;
        bus1.req = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_held();
        test_withdraw();
        test_reset_midop();
        test_ack_dly1();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
